// File: rtl/stack_ctrl_if.sv
// Request/response and stack-unit bus bundle for the return-address stack controller.
// The controller side uses the slave modport; the requester/stack-unit side uses master.
interface stack_ctrl_if #(
  parameter int unsigned AW    = 19,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  // Pipeline and interrupt requesters
  logic          cpu_call;
  logic          cpu_ret;
  logic [AW-1:0] cpu_addr;
  logic          irq_enter;
  logic          irq_exit;
  logic [AW-1:0] irq_addr;

  // Stack unit
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_pcD;
  logic [AW-1:0] stk_data;

  // Responses and status
  logic          cpu_ack;
  logic          irq_ack;
  logic          ret_valid;
  logic [AW-1:0] ret_addr;
  logic          err;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          unf_err;

  modport slave (
    input  cpu_call, cpu_ret, cpu_addr, irq_enter, irq_exit, irq_addr, stk_data,
    output stk_push, stk_pop, stk_pcD, cpu_ack, irq_ack, ret_valid, ret_addr, err,
           depth, full, empty, ovf_err, unf_err
  );

  modport master (
    output cpu_call, cpu_ret, cpu_addr, irq_enter, irq_exit, irq_addr, stk_data,
    input  stk_push, stk_pop, stk_pcD, cpu_ack, irq_ack, ret_valid, ret_addr, err,
           depth, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Return-address stack controller: arbitrates call/return requests from the pipeline and
// the interrupt unit, issues one push/pop strobe per request and reports the result.
// Each request takes IDLE -> ISSUE -> RESP, so back-to-back requests complete every 3 cycles.
module stack_ctrl #(
  parameter int unsigned AW    = 19,
  parameter int unsigned DEPTH = 256
) (
  input logic         clk,
  input logic         rst,
  stack_ctrl_if.slave bus
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] depth_q;
  logic          push_q, pop_q;
  logic [AW-1:0] pcd_q;
  logic          cpu_ack_q, irq_ack_q;
  logic          ret_valid_q;
  logic [AW-1:0] ret_addr_q;
  logic          err_q, ovf_q, unf_q;

  // Granted operation, held from IDLE through RESP
  logic          is_irq_q, is_push_q, rej_q;

  logic          req_irq, req_any, grant_push, grant_err;
  logic [AW-1:0] grant_addr;

  // Arbitration: irq beats cpu, and within one requester push beats pop
  always_comb begin
    req_irq    = bus.irq_enter | bus.irq_exit;
    req_any    = req_irq | bus.cpu_call | bus.cpu_ret;
    grant_push = req_irq ? bus.irq_enter : bus.cpu_call;
    grant_addr = req_irq ? bus.irq_addr : bus.cpu_addr;
    grant_err  = grant_push ? (depth_q == DepthMax) : (depth_q == '0);
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_any) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, strobes, depth bookkeeping and registered responses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      depth_q     <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      pcd_q       <= '0;
      cpu_ack_q   <= 1'b0;
      irq_ack_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_addr_q  <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      is_irq_q    <= 1'b0;
      is_push_q   <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Strobes and response pulses are single-cycle unless set below
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      irq_ack_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            is_irq_q  <= req_irq;
            is_push_q <= grant_push;
            rej_q     <= grant_err;
            // A rejected request never reaches the stack unit
            push_q    <= grant_push & ~grant_err;
            pop_q     <= ~grant_push & ~grant_err;
            if (grant_push && !grant_err) pcd_q <= grant_addr;
          end
        end
        StIssue: begin
          cpu_ack_q <= ~is_irq_q;
          irq_ack_q <= is_irq_q;
          err_q     <= rej_q;
          if (rej_q) begin
            if (is_push_q) ovf_q <= 1'b1;
            else           unf_q <= 1'b1;
          end else if (is_push_q) begin
            depth_q <= depth_q + 1'b1;
          end else begin
            depth_q     <= depth_q - 1'b1;
            ret_valid_q <= 1'b1;
            // Stack unit has updated stk_data on the falling edge of the pop cycle
            ret_addr_q  <= bus.stk_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stk_push  = push_q;
  assign bus.stk_pop   = pop_q;
  assign bus.stk_pcD   = pcd_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.irq_ack   = irq_ack_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_addr  = ret_addr_q;
  assign bus.err       = err_q;
  assign bus.depth     = depth_q;
  assign bus.full      = (depth_q == DepthMax);
  assign bus.empty     = (depth_q == '0);
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: stack-unit model, queue-based reference model checked every
// cycle, and directed transactions with hand-computed latency/result expectations.
module tb_stack_ctrl;
  localparam int unsigned AW    = 19;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   cmp_en = 1'b0;

  stack_ctrl_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  stack_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stack unit: acts on the strobe and updates stk_data on the falling edge
  logic [AW-1:0] smem [DEPTH];
  int            sp = 0;
  always @(negedge clk) begin
    if (!rst) begin
      sp            <= 0;
      bus.stk_data  <= '0;
    end else if (bus.stk_push && sp < DEPTH) begin
      smem[sp] <= bus.stk_pcD;
      sp       <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_data <= smem[sp-1];
      sp           <= sp - 1;
    end
  end

  // Reference model: a queue of return addresses plus the request timeline
  // (grant on a sampled edge, strobe next cycle, response the cycle after)
  logic [AW-1:0] mq [$];
  int            m_phase = 0;
  bit            m_irq, m_push, m_err;
  logic [AW-1:0] m_addr;
  bit            e_push, e_pop, e_cack, e_iack, e_rv, e_err, e_ovf, e_unf;
  logic [AW-1:0] e_pcd, e_ra;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_phase = 0;
      {e_push, e_pop, e_cack, e_iack, e_rv, e_err, e_ovf, e_unf} = '0;
      e_pcd = '0;
      e_ra  = '0;
    end else if (m_phase == 0) begin
      {e_push, e_pop, e_cack, e_iack, e_rv, e_err} = '0;
      if (bus.irq_enter || bus.irq_exit || bus.cpu_call || bus.cpu_ret) begin
        m_irq  = bus.irq_enter || bus.irq_exit;
        m_push = m_irq ? bus.irq_enter : bus.cpu_call;
        m_addr = m_irq ? bus.irq_addr : bus.cpu_addr;
        m_err  = m_push ? (mq.size() == DEPTH) : (mq.size() == 0);
        e_push = m_push && !m_err;
        e_pop  = !m_push && !m_err;
        if (e_push) e_pcd = m_addr;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      e_push = 1'b0;
      e_pop  = 1'b0;
      if (m_err) begin
        if (m_push) e_ovf = 1'b1;
        else        e_unf = 1'b1;
      end else if (m_push) begin
        mq.push_back(m_addr);
      end else begin
        e_ra = mq.pop_back();
        e_rv = 1'b1;
      end
      e_err   = m_err;
      e_cack  = !m_irq;
      e_iack  = m_irq;
      m_phase = 2;
    end else begin
      {e_cack, e_iack, e_rv, e_err} = '0;
      m_phase = 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("stk_push", bus.stk_push, e_push);
      check("stk_pop", bus.stk_pop, e_pop);
      check("stk_pcD", bus.stk_pcD, e_pcd);
      check("cpu_ack", bus.cpu_ack, e_cack);
      check("irq_ack", bus.irq_ack, e_iack);
      check("ret_valid", bus.ret_valid, e_rv);
      check("ret_addr", bus.ret_addr, e_ra);
      check("err", bus.err, e_err);
      check("depth", bus.depth, mq.size());
      check("full", bus.full, mq.size() == DEPTH);
      check("empty", bus.empty, mq.size() == 0);
      check("ovf_err", bus.ovf_err, e_ovf);
      check("unf_err", bus.unf_err, e_unf);
    end
  end

  // kind: 0 call, 1 ret, 2 irq enter, 3 irq exit
  task automatic set_req(input int kind, input bit v, input logic [AW-1:0] addr);
    case (kind)
      0: begin bus.cpu_call  = v; bus.cpu_addr = addr; end
      1: bus.cpu_ret = v;
      2: begin bus.irq_enter = v; bus.irq_addr = addr; end
      default: bus.irq_exit = v;
    endcase
  endtask

  // One request from idle with literal latency and result expectations
  task automatic txn(input int kind, input logic [AW-1:0] addr, input bit strobe,
                     input bit xerr, input int xdepth, input bit xrv,
                     input logic [AW-1:0] xra);
    @(posedge clk); #1;
    set_req(kind, 1'b1, addr);
    @(posedge clk);
    @(negedge clk);
    check("lat_push", bus.stk_push, (kind == 0 || kind == 2) && strobe);
    check("lat_pop", bus.stk_pop, (kind == 1 || kind == 3) && strobe);
    if (strobe && (kind == 0 || kind == 2)) check("lat_pcd", bus.stk_pcD, addr);
    @(negedge clk);
    check("lat_cpu_ack", bus.cpu_ack, kind < 2);
    check("lat_irq_ack", bus.irq_ack, kind >= 2);
    check("lat_err", bus.err, xerr);
    check("lat_depth", bus.depth, xdepth);
    check("lat_ret_valid", bus.ret_valid, xrv);
    if (xrv) check("lat_ret_addr", bus.ret_addr, xra);
    set_req(kind, 1'b0, addr);
  endtask

  initial begin
    rst = 1'b0;
    bus.cpu_call = 1'b0; bus.cpu_ret = 1'b0; bus.cpu_addr = '0;
    bus.irq_enter = 1'b0; bus.irq_exit = 1'b0; bus.irq_addr = '0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_depth", bus.depth, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_ovf", bus.ovf_err, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Call then return of the same address; then return on empty stack
    txn(0, 19'h00ABC, 1'b1, 1'b0, 1, 1'b0, '0);
    txn(1, '0, 1'b1, 1'b0, 0, 1'b1, 19'h00ABC);
    check("empty_after_ret", bus.empty, 1);
    txn(1, '0, 1'b0, 1'b1, 0, 1'b0, '0);
    check("unf_sticky", bus.unf_err, 1);

    // Simultaneous call and irq enter: irq first, cpu 3 cycles later
    @(posedge clk); #1;
    set_req(0, 1'b1, 19'h00111);
    set_req(2, 1'b1, 19'h00222);
    @(posedge clk);
    @(negedge clk);
    check("arb_push1", bus.stk_push, 1);
    check("arb_pcd1", bus.stk_pcD, 19'h00222);
    @(negedge clk);
    check("arb_irq_ack", bus.irq_ack, 1);
    check("arb_cpu_ack0", bus.cpu_ack, 0);
    set_req(2, 1'b0, 19'h00222);
    @(negedge clk);
    @(negedge clk);
    check("arb_push2", bus.stk_push, 1);
    check("arb_pcd2", bus.stk_pcD, 19'h00111);
    @(negedge clk);
    check("arb_cpu_ack", bus.cpu_ack, 1);
    check("arb_depth", bus.depth, 2);
    set_req(0, 1'b0, 19'h00111);

    // Fill to DEPTH, then overflow
    txn(0, 19'h00333, 1'b1, 1'b0, 3, 1'b0, '0);
    txn(2, 19'h00444, 1'b1, 1'b0, 4, 1'b0, '0);
    check("full_at_4", bus.full, 1);
    txn(0, 19'h00555, 1'b0, 1'b1, 4, 1'b0, '0);
    check("ovf_sticky", bus.ovf_err, 1);
    check("full_after_ovf", bus.full, 1);
    txn(3, '0, 1'b1, 1'b0, 3, 1'b1, 19'h00444);

    // Call and ret held together: push wins, pop follows
    @(posedge clk); #1;
    set_req(0, 1'b1, 19'h00666);
    set_req(1, 1'b1, '0);
    @(posedge clk);
    @(negedge clk);
    check("pp_push", bus.stk_push, 1);
    check("pp_no_pop", bus.stk_pop, 0);
    @(negedge clk);
    check("pp_depth4", bus.depth, 4);
    set_req(0, 1'b0, 19'h00666);
    @(negedge clk);
    @(negedge clk);
    check("pp_pop", bus.stk_pop, 1);
    @(negedge clk);
    check("pp_ret_valid", bus.ret_valid, 1);
    check("pp_ret_addr", bus.ret_addr, 19'h00666);
    check("pp_depth3", bus.depth, 3);
    set_req(1, 1'b0, '0);

    // irq_exit pulsed while busy and withdrawn before idle: never serviced
    @(posedge clk); #1;
    set_req(0, 1'b1, 19'h00777);
    @(posedge clk); #1;
    set_req(3, 1'b1, '0);
    @(posedge clk); #1;
    set_req(3, 1'b0, '0);
    @(negedge clk);
    check("wd_cpu_ack", bus.cpu_ack, 1);
    set_req(0, 1'b0, 19'h00777);
    repeat (3) begin
      @(negedge clk);
      check("wd_no_pop", bus.stk_pop, 0);
      check("wd_no_irq_ack", bus.irq_ack, 0);
    end
    check("wd_depth", bus.depth, 4);

    // Reset asserted during ISSUE aborts the pop
    @(posedge clk); #1;
    set_req(1, 1'b1, '0);
    @(posedge clk);
    @(negedge clk);
    check("ra_pop", bus.stk_pop, 1);
    rst = 1'b0;
    set_req(1, 1'b0, '0);
    @(negedge clk);
    check("ra_pop0", bus.stk_pop, 0);
    check("ra_ack0", bus.cpu_ack, 0);
    check("ra_rv0", bus.ret_valid, 0);
    check("ra_depth", bus.depth, 0);
    check("ra_ovf", bus.ovf_err, 0);
    check("ra_unf", bus.unf_err, 0);
    check("ra_ret_addr", bus.ret_addr, 0);
    check("ra_pcd", bus.stk_pcD, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Normal operation resumes from an empty stack
    txn(0, 19'h00ABC, 1'b1, 1'b0, 1, 1'b0, '0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter AW, default 19, return-address width.
REQ-002 SHALL have parameter DEPTH, default 256, maximum stack entries.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cpu_call  input  1  pipeline push request, level, held until cpu_ack.
REQ-006 SHALL have port cpu_ret  input  1  pipeline pop request, level, held until cpu_ack.
REQ-007 SHALL have port cpu_addr  input  AW  address to push for cpu_call.
REQ-008 SHALL have port irq_enter  input  1  interrupt push request, level, held until irq_ack.
REQ-009 SHALL have port irq_exit  input  1  interrupt pop request, level, held until irq_ack.
REQ-010 SHALL have port irq_addr  input  AW  address to push for irq_enter.
REQ-011 SHALL have port stk_push  output  1  push strobe to stack unit.
REQ-012 SHALL have port stk_pop  output  1  pop strobe to stack unit.
REQ-013 SHALL have port stk_pcD  output  AW  data to stack unit.
REQ-014 SHALL have port stk_data  input  AW  popped data from stack unit (updated on falling edge of the strobe cycle).
REQ-015 SHALL have port cpu_ack, irq_ack  output  1 each  one-cycle completion pulse.
REQ-016 SHALL have port ret_valid  output  1  one-cycle pulse; ret_addr valid.
REQ-017 SHALL have port ret_addr  output  AW  popped return address.
REQ-018 SHALL have port err  output  1  rejected-request flag, valid with the ack.
REQ-019 SHALL have ports depth (output, clog2(DEPTH)+1), full, empty (output, 1 each).
REQ-020 SHALL have ports ovf_err, unf_err  output  1 each  sticky fault flags.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE.
REQ-022 In IDLE with any request, SHALL grant irq (irq_enter/irq_exit) over cpu (cpu_call/cpu_ret) and enter ISSUE.
REQ-023 If one requester raises both push and pop, push SHALL win; pop stays pending.
REQ-024 In ISSUE, exactly one of stk_push/stk_pop SHALL be high for exactly one cycle; stk_pcD = granted address on push.
REQ-025 In ISSUE, depth SHALL update: +1 on push, -1 on pop.
REQ-026 In RESP, the granted ack SHALL pulse one cycle; on pop, ret_valid SHALL pulse and ret_addr SHALL be stk_data captured at the ISSUE->RESP edge.
REQ-027 Latency: request sampled at edge N, strobe in cycle N+1, ack/ret_valid in cycle N+2; back-to-back requests SHALL have 3-cycle throughput.
REQ-028 Push with depth==DEPTH SHALL skip the strobe, leave depth unchanged, set ovf_err, assert err with the ack.
REQ-029 Pop with depth==0 SHALL skip the strobe, set unf_err, assert err with the ack, keep ret_valid low.
REQ-030 full SHALL equal (depth==DEPTH); empty SHALL equal (depth==0); both combinational from depth.
REQ-031 A request deasserted before its ack SHALL not be serviced if it is still in IDLE; once granted it SHALL complete.
REQ-032 Outputs other than full/empty SHALL be registered.

Reset
REQ-033 rst low at a rising edge SHALL force IDLE, depth=0, and all strobes, acks, ret_valid, err, ovf_err, unf_err, ret_addr, stk_pcD = 0 at the same edge, aborting any in-flight operation.
REQ-034 ovf_err/unf_err SHALL clear only by reset.

Verification
REQ-035 cpu_call, cpu_addr=19'h00ABC -> stk_push one cycle at N+1 with stk_pcD=19'h00ABC; cpu_ack at N+2; depth=1.
REQ-036 Then cpu_ret, model stk_data=19'h00ABC -> stk_pop at N+1; ret_valid and ret_addr=19'h00ABC at N+2; depth=0, empty=1.
REQ-037 cpu_call and irq_enter raised in the same cycle -> irq serviced first (irq_ack), cpu_ack 3 cycles later; depth=2.
REQ-038 DEPTH=4, five calls -> fifth gets no strobe, cpu_ack with err=1, ovf_err=1, depth=4, full=1.
REQ-039 cpu_ret at depth=0 -> no strobe, err=1, unf_err=1, ret_valid=0.
REQ-040 rst low during ISSUE -> next cycle all outputs 0, no ack, depth=0, FSM IDLE.
